// File: rtl/pico_if_pkg.sv
// Definitions shared by the Pico <-> 68k parallel link (receive and transmit sides).
// Register offsets, STATUS bit layout, default window address and the access FSM states.
package pico_if_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_IRQ_EN   = 3;
  localparam int ST_PHASE    = 4;
  localparam int ST_CNT_LSB  = 5;
  localparam int ST_CNT_MSB  = 7;

  localparam logic [22:0] DEFAULT_BASE_ADDR = 23'h7FF800;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_ACK  = 2'd1,
    ACC_HOLD = 2'd2
  } acc_state_e;

  function automatic logic [2:0] sat_count3(input logic [31:0] cnt);
    if (cnt > 32'd7) begin
      return 3'd7;
    end else begin
      return cnt[2:0];
    end
  endfunction

endpackage

// File: rtl/pico_rx_fifo.sv
// Small synchronous word FIFO with flush; a pop frees a slot for a push in the same cycle.
module pico_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pico_rx.sv
// Pico -> 68k receive path: strobe synchroniser, byte pairing, word FIFO and a
// two-register 68k window (DATA / STATUS) with self-generated DTACK and PBUSY flow control.
module pico_rx
  import pico_if_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PD,
  input  logic        PSTB,
  output logic        PBUSY,
  input  logic        AS,
  input  logic        RW,
  input  logic        UDS,
  input  logic        LDS,
  input  logic [23:1] A,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK_OUT,
  output logic        DTACK_OE,
  output logic        IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   strobe_s;
  logic                   phase_r;
  logic [7:0]             hi_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   flush_s;
  logic                   wr_status_s;
  logic                   ovf_set_s;
  logic [15:0]            head_s;
  logic [CW-1:0]          count_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   ovf_r;
  logic                   irq_en_r;
  logic                   hit_s;
  logic                   acc_rw_r;
  logic                   acc_sel_r;
  logic [15:0]            status_s;
  logic [15:0]            rdata_s;
  acc_state_e             state_r;
  acc_state_e             state_nxt_s;
  logic                   unused_s;

  // Byte strobes do not qualify the decode, and only STATUS control bits are written.
  assign unused_s = ^{UDS, LDS, D_IN[15:5], D_IN[1:0]};

  // PSTB synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r[0] <= PSTB;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign strobe_s = sync_r[SYNC_STAGES-1] & ~hist_r;

  // Access decode and FIFO control strobes for the ACK cycle.
  always_comb begin
    hit_s       = (A[23:2] == BASE_ADDR[22:1]);
    pop_s       = (state_r == ACC_ACK) & acc_rw_r & (acc_sel_r == REG_DATA);
    wr_status_s = (state_r == ACC_ACK) & ~acc_rw_r & (acc_sel_r == REG_STATUS);
    flush_s     = wr_status_s & D_IN[ST_PHASE];
    push_s      = strobe_s & phase_r & ~flush_s;
    ovf_set_s   = push_s & full_s & ~pop_s;
    status_s    = {8'h00, sat_count3(32'(count_s)), phase_r, irq_en_r, ovf_r, full_s, ~empty_s};
    if (acc_sel_r == REG_STATUS) begin
      rdata_s = status_s;
    end else if (empty_s) begin
      rdata_s = 16'h0000;
    end else begin
      rdata_s = head_s;
    end
  end

  // Byte pairing: first byte parks in hi_r, second completes the word; flush realigns.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_r <= 1'b0;
      hi_r    <= 8'h00;
    end else if (flush_s) begin
      phase_r <= 1'b0;
    end else if (strobe_s) begin
      if (!phase_r) begin
        hi_r <= PD;
      end
      phase_r <= ~phase_r;
    end
  end

  pico_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (16)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   ({hi_r, PD}),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sticky overflow (a new overflow beats a clear), interrupt enable, PBUSY and IRQ.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf_r    <= 1'b0;
      irq_en_r <= 1'b0;
      PBUSY    <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && D_IN[ST_OVERFLOW]) begin
        ovf_r <= 1'b0;
      end
      if (wr_status_s) begin
        irq_en_r <= D_IN[ST_IRQ_EN];
      end
      PBUSY <= (count_s >= CW'(FIFO_DEPTH - 1));
      IRQ   <= irq_en_r & ~empty_s;
    end
  end

  // Access FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACC_IDLE: begin
        if (!AS && hit_s) begin
          state_nxt_s = ACC_ACK;
        end else begin
          state_nxt_s = ACC_IDLE;
        end
      end
      ACC_ACK:  state_nxt_s = ACC_HOLD;
      ACC_HOLD: begin
        if (AS) begin
          state_nxt_s = ACC_IDLE;
        end else begin
          state_nxt_s = ACC_HOLD;
        end
      end
      default:  state_nxt_s = ACC_IDLE;
    endcase
  end

  // State register; direction and register select are latched when the cycle is accepted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ACC_IDLE;
      acc_rw_r  <= 1'b0;
      acc_sel_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ACC_IDLE) begin
        acc_rw_r  <= RW;
        acc_sel_r <= A[1];
      end
    end
  end

  // Registered bus outputs: asserted in ACK, held through HOLD, released when AS rises.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      D_OUT     <= 16'h0000;
      D_OE      <= 1'b0;
      DTACK_OUT <= 1'b1;
      DTACK_OE  <= 1'b0;
    end else begin
      case (state_r)
        ACC_ACK: begin
          if (acc_rw_r) begin
            D_OUT <= rdata_s;
            D_OE  <= 1'b1;
          end
          DTACK_OE  <= 1'b1;
          DTACK_OUT <= 1'b0;
        end
        ACC_HOLD: begin
          if (AS) begin
            D_OE      <= 1'b0;
            DTACK_OE  <= 1'b0;
            DTACK_OUT <= 1'b1;
          end
        end
        default: begin
          D_OE      <= 1'b0;
          DTACK_OE  <= 1'b0;
          DTACK_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pico_rx.sv
// Self-checking bench for pico_rx: a reference model of the FIFO/status state predicts
// each bus read; expected values are queued at stimulus time and popped at DTACK.
module tb_pico_rx;
  import pico_if_pkg::*;

  localparam logic [22:0] BASE = 23'h7FF800;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PD;
  logic        PSTB;
  logic        PBUSY;
  logic        AS;
  logic        RW;
  logic        UDS;
  logic        LDS;
  logic [23:1] A;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        DTACK_OUT;
  logic        DTACK_OE;
  logic        IRQ;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mq[$];
  logic        m_ovf;
  logic        m_irq_en;
  logic        m_phase;
  logic [7:0]  m_hi;

  pico_rx dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PD        (PD),
    .PSTB      (PSTB),
    .PBUSY     (PBUSY),
    .AS        (AS),
    .RW        (RW),
    .UDS       (UDS),
    .LDS       (LDS),
    .A         (A),
    .D_IN      (D_IN),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .DTACK_OUT (DTACK_OUT),
    .DTACK_OE  (DTACK_OE),
    .IRQ       (IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    int n;
    logic [2:0] c3;
    n  = mq.size();
    c3 = (n > 7) ? 3'd7 : 3'(n);
    return {8'h00, c3, m_phase, m_irq_en, m_ovf, (n == 4), (n != 0)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_phase  = 1'b0;
    m_hi     = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1 PD = b;
    repeat (4) @(posedge CLK);
    #1 PSTB = 1'b1;
    repeat (6) @(posedge CLK);
    #1 PSTB = 1'b0;
    repeat (4) @(posedge CLK);
    if (!m_phase) begin
      m_hi    = b;
      m_phase = 1'b1;
    end else begin
      if (mq.size() < 4) mq.push_back({m_hi, b});
      else m_ovf = 1'b1;
      m_phase = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_flags(input string tag);
    #1;
    check_value({tag, "_pbusy"}, PBUSY, (mq.size() >= 3));
    check_value({tag, "_irq"}, IRQ, (m_irq_en && mq.size() != 0));
  endtask

  task automatic bus_start(input logic sel, input logic rw, input logic [15:0] wd, input string tag);
    int n;
    logic [15:0] e;
    if (rw) begin
      if (sel == REG_DATA) e = (mq.size() != 0) ? mq.pop_front() : 16'h0000;
      else e = model_status();
      exp_q.push_back(e);
    end else if (sel == REG_STATUS) begin
      m_irq_en = wd[3];
      if (wd[2]) m_ovf = 1'b0;
      if (wd[4]) begin
        mq.delete();
        m_phase = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    A = {BASE[22:1], sel};
    RW = rw; D_IN = wd; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
    n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (!DTACK_OE && n < 8);
    check_value({tag, "_dtack_lat"}, n, 2);
    check_value({tag, "_dtack_lvl"}, DTACK_OUT, 1'b0);
    if (rw) begin
      e = exp_q.pop_front();
      check_value({tag, "_doe"}, D_OE, 1'b1);
      check_value({tag, "_data"}, D_OUT, e);
    end else begin
      check_value({tag, "_doe_wr"}, D_OE, 1'b0);
    end
  endtask

  task automatic bus_end(input string tag);
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    @(posedge CLK); #1;
    check_value({tag, "_rel"}, {D_OE, DTACK_OE, DTACK_OUT}, 3'b001);
  endtask

  task automatic bus_read(input logic sel, input string tag);
    bus_start(sel, 1'b1, 16'h0000, tag);
    bus_end(tag);
  endtask

  task automatic bus_write(input logic sel, input logic [15:0] wd, input string tag);
    bus_start(sel, 1'b0, wd, tag);
    bus_end(tag);
  endtask

  initial begin
    logic seen;
    logic [15:0] w;
    RESET = 1'b0; PD = 8'h00; PSTB = 1'b0; AS = 1'b1; RW = 1'b1;
    UDS = 1'b1; LDS = 1'b1; A = 23'h000000; D_IN = 16'h0000;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_value("rst_dout", D_OUT, 16'h0000);
    check_value("rst_oe", {D_OE, DTACK_OE}, 2'b00);
    check_value("rst_dtack", DTACK_OUT, 1'b1);
    check_value("rst_pbusy_irq", {PBUSY, IRQ}, 2'b00);
    RESET = 1'b1;

    // Basic pairing and read
    send_byte(8'h12);
    send_byte(8'h34);
    bus_read(REG_DATA, "rd1234");
    bus_read(REG_STATUS, "st_after");

    // Fill, PBUSY, overflow, drain, clear
    send_word(16'h0001);
    send_word(16'h0002);
    check_flags("two");
    send_word(16'h0003);
    check_flags("three");
    send_word(16'h0004);
    send_word(16'hDEAD);
    bus_read(REG_STATUS, "st_full");
    for (int i = 0; i < 4; i++) bus_read(REG_DATA, "drain");
    bus_read(REG_STATUS, "st_ovf");
    bus_write(REG_STATUS, 16'h0004, "wr_clr");
    bus_read(REG_STATUS, "st_clr");

    // Empty read
    bus_read(REG_DATA, "rd_empty");
    bus_read(REG_STATUS, "st_empty");

    // Phase flush
    send_byte(8'hAB);
    bus_read(REG_STATUS, "st_phase");
    bus_write(REG_STATUS, 16'h0010, "wr_flush");
    bus_read(REG_STATUS, "st_flushed");
    send_word(16'h5678);
    bus_read(REG_DATA, "rd5678");

    // Interrupt
    bus_write(REG_STATUS, 16'h0008, "wr_irqen");
    repeat (2) @(posedge CLK);
    check_flags("irq_empty");
    send_word(16'h9ABC);
    check_flags("irq_word");
    bus_read(REG_DATA, "rd9abc");
    repeat (2) @(posedge CLK);
    check_flags("irq_popped");

    // DATA write is ignored; non-hit access never acked
    send_word(16'h4242);
    bus_write(REG_DATA, 16'hFFFF, "wr_data");
    bus_read(REG_STATUS, "st_wrdata");
    @(posedge CLK); #1;
    A = 23'h123456; RW = 1'b1; AS = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      seen = seen | D_OE | DTACK_OE | ~DTACK_OUT;
    end
    check_value("nohit", seen, 1'b0);
    AS = 1'b1;
    bus_read(REG_DATA, "rd4242");

    // Random words round trip
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      send_word(w);
      bus_read(REG_DATA, "rd_rand");
    end

    // Reset during HOLD
    send_word(16'h1111);
    send_word(16'h2222);
    bus_start(REG_DATA, 1'b1, 16'h0000, "rd_hold");
    #2 RESET = 1'b0;
    #1;
    check_value("rst_hold_oe", {D_OE, DTACK_OE}, 2'b00);
    check_value("rst_hold_dtack", DTACK_OUT, 1'b1);
    model_reset();
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    bus_read(REG_STATUS, "st_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pico_rx.md
Name: pico_rx

Overview:
- Receive path from the Pico to the 68k.
- Pico presents bytes on an 8-bit parallel port with a strobe.
- Block synchronises the strobe, pairs bytes into 16-bit words and buffers them in a small FIFO.
- 68k reads the FIFO and a status register via a decoded two-register window with self-generated DTACK; flow control back to the Pico via PBUSY.

Parameters:
BASE_ADDR, 23'h7FF800, word address (A[23:1]) of register window; A[1] selects register, A[23:2] must match BASE_ADDR[22:1]
FIFO_DEPTH, 4, words; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on PSTB

Ports:
CLK  in  1  CPU clock, all logic on rising edge
RESET  in  1  asynchronous, active-low
PD  in  8  Pico data; must be stable >=(SYNC_STAGES+1) CLK either side of PSTB rise
PSTB  in  1  Pico strobe, async; byte valid on rising edge
PBUSY  out  1  high: Pico must not strobe
AS  in  1  68k address strobe, active-low
RW  in  1  1=read
UDS  in  1  active-low
LDS  in  1  active-low
A  in  23  A[23:1]
D_IN  in  16  68k data for writes
D_OUT  out  16  read data
D_OE  out  1  high: top level drives D_OUT onto D
DTACK_OUT  out  1  DTACK level (0 when acking)
DTACK_OE  out  1  high: drive DTACK
IRQ  out  1  active-high interrupt request

Behaviour:
- Reset (async, immediate):
  - D_OUT=0, D_OE=0, DTACK_OUT=1, DTACK_OE=0, PBUSY=0, IRQ=0.
  - FIFO empty, byte phase=0, overflow=0, irq_en=0.
  - A bus cycle in progress is abandoned.
- Strobe path:
  - PSTB through SYNC_STAGES flops plus one history flop.
  - Rising edge detected when sync=1 and history=0; PD captured in that same cycle.
- Byte pairing:
  - Phase 0: byte goes to hi[15:8], phase→1.
  - Phase 1: word {hi,PD} pushed, phase→0.
- Push when FIFO full: word dropped, overflow sticky set.
- PBUSY: high when count>=FIFO_DEPTH-1, registered; leaves one word of margin.
- Registers (A[1]):
  - 0 DATA, read: returns head word and pops once; if empty, returns 0x0000, no pop. Write: acked, ignored.
  - 1 STATUS, read:
    - bit0=nonempty
    - bit1=full
    - bit2=overflow
    - bit3=irq_en
    - bit4=byte phase
    - bits[7:5]=count (saturating at 7)
    - rest 0
  - 1 STATUS, write:
    - bit3 → irq_en
    - bit2=1 clears overflow
    - bit4=1 flushes FIFO and resets phase
- Byte strobes: UDS/LDS are ignored for decode; any strobe combination counts as a full access (a byte read of DATA still pops).
- Access FSM:
  - IDLE: AS=0 and address hit → ACK.
  - ACK (one cycle):
    - Read: D_OUT loaded, D_OE=1, pop performed.
    - Write: register updated.
    - DTACK_OE=1, DTACK_OUT=0.
  - HOLD: outputs held until AS sampled 1, then D_OE=0, DTACK_OE=0, DTACK_OUT=1 → IDLE.
  - DTACK therefore asserts one CLK after AS is first sampled low with hit.
  - Side effect occurs exactly once per bus cycle.
  - No hit: outputs never enabled.
- Simultaneous events:
  - Push+pop: both occur, count unchanged.
  - Push+pop when full: pop frees the slot, push succeeds, no overflow.
  - Flush+push: flush wins, word discarded.
  - Overflow-clear and new overflow in the same cycle: set wins.
- Pointers: wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- IRQ: registered, = irq_en & nonempty.

Decomposition:
- Package pico_if_pkg holds:
  - register offsets (REG_DATA=0, REG_STATUS=1)
  - status bit positions
  - default BASE_ADDR
- Shared with the Pico transmit side.
- One sub-module: pico_rx_fifo (synchronous FIFO; push, pop, flush, head, count, full, empty).

Test Plan:
- Strobe bytes 0x12,0x34 → read DATA returns 0x1234, DTACK asserted one CLK after AS low and released when AS high; STATUS then reads bit0=0.
- Push 4 words (0x0001..0x0004) with no reads → PBUSY high after 3rd word; 5th word 0xDEAD dropped, STATUS bit2=1; reads return 0x0001..0x0004 in order; write STATUS 0x0004 clears bit2.
- Read DATA when empty → D_OUT=0x0000, count stays 0, DTACK still generated.
- Single byte 0xAB, then write STATUS 0x0010 → phase=0, FIFO empty; next bytes 0x56,0x78 yield 0x5678.
- Write STATUS 0x0008 with FIFO empty → IRQ=0; one word pushed → IRQ=1 next cycle; pop → IRQ=0.
- Assert RESET during HOLD with FIFO at count 2 → D_OE, DTACK_OE drop immediately, STATUS reads 0x0000 after reset.
